serdes_lanes: RTL and testbench

SERDES_LANES -- requirements
Module: serdes_lanes

---
 rtl/serdes_lanes.sv | 131 +++++++++++++
 tb/tb_serdes_lanes.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_lanes.sv
// Multi-lane serializer with an on-chip deserializer: shifts a parallel word out
// across LANES serial lanes, optionally appends per-lane even parity, and reassembles it.
module serdes_lanes #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Cin,
  input  logic [DATA_W-1:0] Din,
  input  logic              loopback,
  input  logic [LANES-1:0]  ser_i,
  output logic [LANES-1:0]  ser_o,
  output logic              ser_valid,
  output logic              busy,
  output logic [DATA_W-1:0] Dout,
  output logic              Done,
  output logic              Perr
);

  localparam int BPL = DATA_W / LANES;
  localparam int CW  = $clog2(BPL);
  localparam logic [CW-1:0] LAST = CW'(BPL - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cap_q, cap_d, cap_shift;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CW-1:0]     cnt_q, cnt_d, bit_idx;
  logic              perr_q, perr_d;
  logic [LANES-1:0]  tx_bit, tx_par, rx_par, rx_src;

  // The same bit index selects the transmitted bit and the capture slot, so
  // received bits land back in their original lane positions.
  assign bit_idx = (MSB_FIRST != 0) ? LAST - cnt_q : cnt_q;
  assign rx_src  = loopback ? ser_o : ser_i;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BPL-1:0] tx_lane, rx_lane;
      assign tx_lane    = data_q[gi*BPL +: BPL];
      assign tx_bit[gi] = tx_lane[bit_idx];
      assign tx_par[gi] = ^tx_lane;
      assign rx_par[gi] = ^cap_q[gi*BPL +: BPL];
      always_comb begin
        rx_lane          = cap_q[gi*BPL +: BPL];
        rx_lane[bit_idx] = rx_src[gi];
      end
      assign cap_shift[gi*BPL +: BPL] = rx_lane;
    end
  endgenerate

  always_comb begin
    ser_o = '0;
    unique case (state_q)
      SHIFT:   ser_o = tx_bit;
      PARITY:  ser_o = tx_par;
      default: ser_o = '0;
    endcase
  end

  assign ser_valid = (state_q == SHIFT) || (state_q == PARITY);
  assign busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign Dout      = dout_q;
  assign Perr      = perr_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (Cin) begin
          data_d  = Din;
          cap_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cap_d = cap_shift;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PARITY;
          end else begin
            dout_d  = cap_shift;
            perr_d  = 1'b0;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        dout_d  = cap_q;
        perr_d  = |(rx_src ^ rx_par);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_serdes_lanes.sv
// Directed bench for serdes_lanes: three configurations (1 lane, 4 lanes,
// 1 lane LSB-first without parity) driven by per-scenario tasks.
module tb_serdes_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: DATA_W=32, LANES=1, MSB first, parity on
  logic        rst_a, cin_a, lb_a, valid_a, busy_a, done_a, perr_a;
  logic [31:0] din_a, dout_a;
  logic [0:0]  seri_a, sero_a;
  // Instance B: DATA_W=32, LANES=4
  logic        rst_b, cin_b, lb_b, valid_b, busy_b, done_b, perr_b;
  logic [31:0] din_b, dout_b;
  logic [3:0]  seri_b, sero_b;
  // Instance C: DATA_W=32, LANES=1, LSB first, parity off
  logic        rst_c, cin_c, lb_c, valid_c, busy_c, done_c, perr_c;
  logic [31:0] din_c, dout_c;
  logic [0:0]  seri_c, sero_c;

  serdes_lanes #(.DATA_W(32), .LANES(1), .MSB_FIRST(1), .PARITY_EN(1)) u_a (
    .clk(clk), .rst(rst_a), .Cin(cin_a), .Din(din_a), .loopback(lb_a), .ser_i(seri_a),
    .ser_o(sero_a), .ser_valid(valid_a), .busy(busy_a), .Dout(dout_a), .Done(done_a), .Perr(perr_a));

  serdes_lanes #(.DATA_W(32), .LANES(4), .MSB_FIRST(1), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst_b), .Cin(cin_b), .Din(din_b), .loopback(lb_b), .ser_i(seri_b),
    .ser_o(sero_b), .ser_valid(valid_b), .busy(busy_b), .Dout(dout_b), .Done(done_b), .Perr(perr_b));

  serdes_lanes #(.DATA_W(32), .LANES(1), .MSB_FIRST(0), .PARITY_EN(0)) u_c (
    .clk(clk), .rst(rst_c), .Cin(cin_c), .Din(din_c), .loopback(lb_c), .ser_i(seri_c),
    .ser_o(sero_c), .ser_valid(valid_c), .busy(busy_c), .Dout(dout_c), .Done(done_c), .Perr(perr_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cin_a = 1'b0; cin_b = 1'b0; cin_c = 1'b0;
    lb_a = 1'b1; lb_b = 1'b1; lb_c = 1'b1;
    din_a = '0; din_b = '0; din_c = '0;
    seri_a = '0; seri_b = '0; seri_c = '0;
    tick; tick;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick;
    checks++;
    if ({sero_a, valid_a, busy_a, done_a, perr_a} !== 5'b0) begin
      errors++; $display("FAIL reset_a_ctrl: got %b want 00000", {sero_a, valid_a, busy_a, done_a, perr_a});
    end
    checks++;
    if (dout_a !== 32'h0) begin errors++; $display("FAIL reset_a_dout: got %h want 00000000", dout_a); end
    checks++;
    if ({sero_b, valid_b, busy_b, done_b, perr_b} !== 8'b0) begin
      errors++; $display("FAIL reset_b_ctrl: got %b want 00000000", {sero_b, valid_b, busy_b, done_b, perr_b});
    end
    checks++;
    if (dout_b !== 32'h0) begin errors++; $display("FAIL reset_b_dout: got %h want 00000000", dout_b); end
    checks++;
    if ({sero_c, valid_c, busy_c, done_c, perr_c, dout_c} !== 37'b0) begin
      errors++; $display("FAIL reset_c: got %b/%h want all zero", {sero_c, valid_c, busy_c, done_c, perr_c}, dout_c);
    end
    $display("reset: all instances idle");
  endtask

  task automatic test_lane1_loopback;
    logic [31:0] d;
    int done_cyc, ndone, bad;
    d = 32'hDEADBEEF; done_cyc = -1; ndone = 0; bad = 0;
    lb_a = 1'b1; din_a = d; cin_a = 1'b1;
    tick;
    cin_a = 1'b0; din_a = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc <= 32) begin
        if (sero_a[0] !== d[32-cyc] || valid_a !== 1'b1) bad++;
      end else if (cyc == 33) begin
        if (sero_a[0] !== 1'b0 || valid_a !== 1'b1) bad++;   // DEADBEEF has 24 ones
      end else begin
        if (sero_a[0] !== 1'b0 || valid_a !== 1'b0) bad++;
      end
      if (done_a === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      tick;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lane1_stream: got %0d bad cycles want 0", bad); end
    checks++;
    if (done_cyc != 34) begin errors++; $display("FAIL lane1_latency: got cycle %0d want 34", done_cyc); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL lane1_done_count: got %0d want 1", ndone); end
    checks++;
    if (dout_a !== d) begin errors++; $display("FAIL lane1_dout: got %h want %h", dout_a, d); end
    checks++;
    if (perr_a !== 1'b0) begin errors++; $display("FAIL lane1_perr: got %b want 0", perr_a); end
    $display("xfer a din=%h dout=%h perr=%b done_cycle=%0d", d, dout_a, perr_a, done_cyc);
  endtask

  task automatic test_four_lanes;
    logic [7:0] st [4];
    logic [3:0] par;
    int done_cyc, nvalid;
    for (int l = 0; l < 4; l++) st[l] = '0;
    par = 'x; done_cyc = -1; nvalid = 0;
    lb_b = 1'b1; din_b = 32'h12345678; cin_b = 1'b1;
    tick;
    cin_b = 1'b0; din_b = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc <= 8) for (int l = 0; l < 4; l++) st[l] = {st[l][6:0], sero_b[l]};
      if (cyc == 9) par = sero_b;
      if (valid_b === 1'b1) nvalid++;
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = cyc;
      tick;
    end
    checks++;
    if (st[0] !== 8'h78) begin errors++; $display("FAIL four_lane0: got %h want 78", st[0]); end
    checks++;
    if (st[1] !== 8'h56) begin errors++; $display("FAIL four_lane1: got %h want 56", st[1]); end
    checks++;
    if (st[2] !== 8'h34) begin errors++; $display("FAIL four_lane2: got %h want 34", st[2]); end
    checks++;
    if (st[3] !== 8'h12) begin errors++; $display("FAIL four_lane3: got %h want 12", st[3]); end
    checks++;
    if (par !== 4'b0100) begin errors++; $display("FAIL four_parity_bits: got %b want 0100", par); end
    checks++;
    if (nvalid != 9) begin errors++; $display("FAIL four_valid_cycles: got %0d want 9", nvalid); end
    checks++;
    if (done_cyc != 10) begin errors++; $display("FAIL four_latency: got cycle %0d want 10", done_cyc); end
    checks++;
    if (dout_b !== 32'h12345678 || perr_b !== 1'b0) begin
      errors++; $display("FAIL four_dout: got %h/%b want 12345678/0", dout_b, perr_b);
    end
    $display("xfer b din=12345678 dout=%h perr=%b done_cycle=%0d", dout_b, perr_b, done_cyc);
  endtask

  // External-path transfer; optionally corrupts lane 2 data bit 3 (sent in cycle 5)
  task automatic xfer_b_ext(input logic [31:0] d, input bit inv, output int done_cyc);
    lb_b = 1'b0; din_b = d; cin_b = 1'b1; seri_b = '0;
    tick;
    cin_b = 1'b0; din_b = '0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      seri_b = sero_b ^ ((inv && cyc == 5) ? 4'b0100 : 4'b0000);
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = cyc;
      tick;
    end
    seri_b = '0;
  endtask

  task automatic test_parity_error;
    int dc;
    xfer_b_ext(32'h12345678, 1'b1, dc);
    checks++;
    if (perr_b !== 1'b1) begin errors++; $display("FAIL perr_inverted: got %b want 1", perr_b); end
    checks++;
    if (dout_b !== 32'h123C5678) begin errors++; $display("FAIL perr_inverted_dout: got %h want 123c5678", dout_b); end
    checks++;
    if (dc != 10) begin errors++; $display("FAIL perr_inverted_latency: got %0d want 10", dc); end
    $display("xfer b ext inv=1 dout=%h perr=%b", dout_b, perr_b);
    xfer_b_ext(32'h12345678, 1'b0, dc);
    checks++;
    if (perr_b !== 1'b0 || dout_b !== 32'h12345678) begin
      errors++; $display("FAIL perr_clean: got %h/%b want 12345678/0", dout_b, perr_b);
    end
    $display("xfer b ext inv=0 dout=%h perr=%b", dout_b, perr_b);
    lb_b = 1'b1;
  endtask

  task automatic test_back_to_back;
    int done_cyc;
    lb_b = 1'b1; din_b = 32'hA5A50F0F; cin_b = 1'b1;
    tick;
    cin_b = 1'b0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (cyc < 10) tick;
    end
    checks++;
    if (done_cyc != 10 || dout_b !== 32'hA5A50F0F) begin
      errors++; $display("FAIL b2b_first: got cycle %0d dout %h want 10/a5a50f0f", done_cyc, dout_b);
    end
    $display("xfer b din=a5a50f0f dout=%h", dout_b);
    tick;  // cycle 11: IDLE
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy_b); end
    din_b = 32'h3C3CF0F0; cin_b = 1'b1;
    tick;
    cin_b = 1'b0;
    checks++;
    if (busy_b !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b want 1", busy_b); end
    done_cyc = -1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc == 4) begin din_b = 32'hFFFFFFFF; cin_b = 1'b1; end   // must be ignored
      if (cyc == 5) cin_b = 1'b0;
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (cyc < 11) tick;
    end
    checks++;
    if (done_cyc != 10 || dout_b !== 32'h3C3CF0F0) begin
      errors++; $display("FAIL b2b_second: got cycle %0d dout %h want 10/3c3cf0f0", done_cyc, dout_b);
    end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL busy_cin_ignored: got busy %b want 0", busy_b); end
    $display("xfer b din=3c3cf0f0 dout=%h", dout_b);
    din_b = '0;
  endtask

  task automatic test_cin_held;
    int starts, dones, bad;
    logic prev;
    logic [31:0] d;
    d = 32'h5A5AC3C3; starts = 0; dones = 0; bad = 0;
    lb_a = 1'b1; din_a = d; cin_a = 1'b1; prev = busy_a;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) cin_a = 1'b0;
      tick;
      if (busy_a === 1'b1 && prev === 1'b0) starts++;
      prev = busy_a;
      if (done_a === 1'b1) begin
        dones++;
        if (dout_a !== d) bad++;
      end
    end
    checks++;
    if (starts != 2) begin errors++; $display("FAIL cin_held_starts: got %0d want 2", starts); end
    checks++;
    if (dones != 2 || bad != 0) begin
      errors++; $display("FAIL cin_held_dones: got %0d dones %0d bad want 2/0", dones, bad);
    end
    $display("xfer a cin held 40 cycles: starts=%0d dones=%0d", starts, dones);
  endtask

  task automatic test_reset_mid;
    int ndone, done_cyc;
    lb_a = 1'b1; din_a = 32'hCAFEF00D; cin_a = 1'b1;
    tick;
    cin_a = 1'b0;
    repeat (4) tick;   // now in SHIFT cycle 5
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    checks++;
    if ({sero_a, valid_a, busy_a, done_a, perr_a} !== 5'b0 || dout_a !== 32'h0) begin
      errors++; $display("FAIL reset_mid: got %b/%h want all zero", {sero_a, valid_a, busy_a, done_a, perr_a}, dout_a);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a === 1'b1) ndone++;
      tick;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d want 0", ndone); end
    din_a = 32'h0F1E2D3C; cin_a = 1'b1;
    tick;
    cin_a = 1'b0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (done_a === 1'b1 && done_cyc < 0) done_cyc = cyc;
      tick;
    end
    checks++;
    if (done_cyc != 34 || dout_a !== 32'h0F1E2D3C || perr_a !== 1'b0) begin
      errors++; $display("FAIL reset_mid_recover: got cycle %0d dout %h perr %b want 34/0f1e2d3c/0", done_cyc, dout_a, perr_a);
    end
    $display("xfer a after abort din=0f1e2d3c dout=%h done_cycle=%0d", dout_a, done_cyc);
  endtask

  task automatic test_lsb_nopar;
    logic [31:0] vec [2];
    int exp_pos [2];
    int ones, first_one, nvalid, done_cyc;
    vec[0] = 32'h00000001; exp_pos[0] = 1;
    vec[1] = 32'h80000000; exp_pos[1] = 32;
    lb_c = 1'b1;
    for (int v = 0; v < 2; v++) begin
      ones = 0; first_one = -1; nvalid = 0; done_cyc = -1;
      din_c = vec[v]; cin_c = 1'b1;
      tick;
      cin_c = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        if (sero_c[0] === 1'b1) begin
          ones++;
          if (first_one < 0) first_one = cyc;
        end
        if (valid_c === 1'b1) nvalid++;
        if (done_c === 1'b1 && done_cyc < 0) done_cyc = cyc;
        tick;
      end
      checks++;
      if (ones != 1 || first_one != exp_pos[v]) begin
        errors++; $display("FAIL lsb_stream_%0d: got %0d ones at cycle %0d want 1 at %0d", v, ones, first_one, exp_pos[v]);
      end
      checks++;
      if (nvalid != 32) begin errors++; $display("FAIL lsb_valid_%0d: got %0d want 32", v, nvalid); end
      checks++;
      if (done_cyc != 33) begin errors++; $display("FAIL lsb_latency_%0d: got %0d want 33", v, done_cyc); end
      checks++;
      if (dout_c !== vec[v] || perr_c !== 1'b0) begin
        errors++; $display("FAIL lsb_dout_%0d: got %h/%b want %h/0", v, dout_c, perr_c, vec[v]);
      end
      $display("xfer c din=%h dout=%h perr=%b done_cycle=%0d", vec[v], dout_c, perr_c, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_lane1_loopback();
    test_four_lanes();
    test_parity_error();
    test_back_to_back();
    test_cin_held();
    test_reset_mid();
    test_lsb_nopar();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
